// File: rtl/cipher_seq_ctrl.sv
// Sequencer for the 8-byte shift-XOR stream cipher: byte loads become encrypt/inc strobes, reads walk the byte select.
// Optional sticky overflow flag: define CIPHER_OVERFLOW_FLAG_EN.
module cipher_seq_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int DEPTH         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       rd_start,
  input  logic       rd_view,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       rd_done,
  output logic [3:0] count,
  output logic [7:0] cph_data,
  output logic       cph_encrypt,
  output logic       cph_inc,
  output logic [2:0] cph_ct,
  output logic       cph_view,
  input  logic [7:0] cph_rd,
  output logic       overflow
);

  generate
    if (DEPTH != 8) begin : g_depth_chk
      $error("cipher_seq_ctrl: DEPTH must be 8");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 4) begin : g_settle_chk
      $error("cipher_seq_ctrl: SETTLE_CYCLES must be 1..4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, LD_SETUP, LD_PULSE, LD_HOLD, RD_SET, RD_WAIT, RD_OUT, RD_DONE
  } state_t;

  localparam logic [3:0] FULL_CNT    = 4'(DEPTH);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  state_t     state_r;
  logic [1:0] wait_r;

  // Main sequencer; cph_ct doubles as the read index so the select line is always registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wait_r      <= 2'd0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      rd_done     <= 1'b0;
      count       <= 4'd0;
      cph_data    <= 8'h00;
      cph_encrypt <= 1'b0;
      cph_inc     <= 1'b0;
      cph_ct      <= 3'd0;
      cph_view    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rd_done <= 1'b0;
          if (in_valid && in_ready) begin
            cph_data    <= in_data;
            cph_encrypt <= 1'b1;
            in_ready    <= 1'b0;
            state_r     <= LD_SETUP;
          end else if (rd_start) begin
            in_ready <= 1'b0;
            if (count == 4'd0) begin
              rd_done <= 1'b1;
              state_r <= RD_DONE;
            end else begin
              cph_ct   <= 3'(count - 4'd1);
              cph_view <= rd_view;
              state_r  <= RD_SET;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        LD_SETUP: begin
          cph_inc <= 1'b1;
          state_r <= LD_PULSE;
        end
        LD_PULSE: begin
          cph_inc <= 1'b0;
          state_r <= LD_HOLD;
        end
        LD_HOLD: begin
          cph_encrypt <= 1'b0;
          in_ready    <= 1'b1;
          if (count != FULL_CNT) begin
            count <= count + 4'd1;
          end else begin
            count <= count;
          end
          state_r <= IDLE;
        end
        RD_SET: begin
          cph_encrypt <= 1'b0;
          wait_r      <= 2'd0;
          state_r     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_r == SETTLE_LAST) begin
            out_data  <= cph_rd;
            out_valid <= 1'b1;
            state_r   <= RD_OUT;
          end else begin
            wait_r <= wait_r + 2'd1;
          end
        end
        RD_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cph_ct == 3'd0) begin
              rd_done <= 1'b1;
              state_r <= RD_DONE;
            end else begin
              cph_ct  <= cph_ct - 3'd1;
              state_r <= RD_SET;
            end
          end else begin
            out_valid <= 1'b1;
          end
        end
        RD_DONE: begin
          rd_done  <= 1'b0;
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          cph_inc     <= 1'b0;
          cph_encrypt <= 1'b0;
          out_valid   <= 1'b0;
          rd_done     <= 1'b0;
          in_ready    <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef CIPHER_OVERFLOW_FLAG_EN
  logic overflow_r;

  // Sticky flag: a load while already full has discarded the oldest byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (state_r == LD_HOLD && count == FULL_CNT) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Directed bench for cipher_seq_ctrl with a behavioural model of the shift-XOR cipher.
module tb_cipher_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       rd_start = 1'b0;
  logic       rd_view = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       rd_done;
  logic [3:0] count;
  logic [7:0] cph_data;
  logic       cph_encrypt;
  logic       cph_inc;
  logic [2:0] cph_ct;
  logic       cph_view;
  logic [7:0] cph_rd;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cipher_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_start(rd_start), .rd_view(rd_view), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .rd_done(rd_done), .count(count), .cph_data(cph_data),
    .cph_encrypt(cph_encrypt), .cph_inc(cph_inc), .cph_ct(cph_ct), .cph_view(cph_view),
    .cph_rd(cph_rd), .overflow(overflow)
  );

  // Cipher model: mem[0] is the newest byte, stored as plain ^ previous newest.
  logic [7:0] mem [8];
  logic [2:0] ct_up;
  always @(posedge cph_inc or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mem[k] <= 8'h00;
    end else if (cph_encrypt) begin
      for (int k = 7; k > 0; k--) mem[k] <= mem[k-1];
      mem[0] <= cph_data ^ mem[0];
    end
  end
  always_comb begin
    ct_up = cph_ct + 3'd1;
    if (cph_view) cph_rd = mem[cph_ct];
    else if (cph_ct == 3'd7) cph_rd = mem[7];
    else cph_rd = mem[cph_ct] ^ mem[ct_up];
  end

  typedef struct {
    logic       iv;  logic [7:0] id; logic rs; logic rv; logic ordy;
    logic       e_ir; logic e_inc; logic e_enc; logic [7:0] e_data;
    logic [3:0] e_cnt; logic e_ov; logic [7:0] e_od; logic e_done;
  } vec_t;
  vec_t tbl [24];

  logic [7:0] got_q [$];
  logic [7:0] exp_b [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) timeout_fail("load_wait");
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic dump(input logic view);
    int  guard;
    bit  done;
    got_q.delete();
    guard = 0; done = 1'b0;
    rd_view = view; rd_start = 1'b1; out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    while (!done && guard < 200) begin
      if (out_valid) got_q.push_back(out_data);
      if (rd_done) done = 1'b1;
      else tick();
      guard++;
    end
    if (!done) timeout_fail("dump_done");
    tick();
    chk("rd_done_single", rd_done, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    // iv id rs rv ordy | ir inc enc data cnt ov od done
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 4'd0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 4'd0, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 4'd0, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 4'd1, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 4'd1, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 4'd1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 4'd1, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h42, 4'd2, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 4'd2, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 4'd2, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 4'd2, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b1, 8'h41, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b1, 8'h42, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b1, 8'h43, 1'b0};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b1};
    tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h43, 4'd3, 1'b0, 8'h00, 1'b0};

    // Reset values
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_cph_inc", cph_inc, 1'b0);
    chk("rst_cph_encrypt", cph_encrypt, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // Cycle-by-cycle table: loads 'A','B', load-beats-read 'C', then decrypted dump
    for (int i = 0; i < 24; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; rd_start = tbl[i].rs;
      rd_view = tbl[i].rv; out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_cph_inc", i), cph_inc, tbl[i].e_inc);
      chk($sformatf("v%0d_cph_encrypt", i), cph_encrypt, tbl[i].e_enc);
      chk($sformatf("v%0d_cph_data", i), cph_data, tbl[i].e_data);
      chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("v%0d_rd_done", i), rd_done, tbl[i].e_done);
    end
    in_valid = 1'b0; rd_start = 1'b0; out_ready = 1'b0;

    // Encrypted view of "ABC": stored 0x41, 0x42^0x41, 0x43^0x03, oldest first
    dump(1'b1);
    chk("enc_len", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("enc_b0", got_q[0], 8'h41);
      chk("enc_b1", got_q[1], 8'h03);
      chk("enc_b2", got_q[2], 8'h40);
    end
    chk("count_after_read", count, 4'd3);

    // Wrap-around: 10 loads, count saturates, overflow only from the 9th load on
    do_reset();
    for (int b = 1; b <= 10; b++) begin
      load_byte(8'(b));
      if (b == 8) chk("ovf_after_8", overflow, 1'b0);
`ifdef CIPHER_OVERFLOW_FLAG_EN
      if (b == 9) chk("ovf_after_9", overflow, 1'b1);
`else
      if (b == 9) chk("ovf_after_9", overflow, 1'b0);
`endif
    end
    chk("count_sat", count, 4'd8);
    // idx 7 decrypted view is the raw stored byte (0x03 ^ 0x03 = 0x00)
    exp_b = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    dump(1'b0);
    chk("wrap_len", got_q.size(), 8);
    if (got_q.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("wrap_b%0d", k), got_q[k], exp_b[k]);

    // Back-pressure: out_ready low 5 cycles, pending in_valid must wait for rd_done
    load_byte(8'h5A);
    rd_view = 1'b0; rd_start = 1'b1; out_ready = 1'b0;
    tick();
    rd_start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      if (n >= 20) timeout_fail("stall_valid");
      for (int c = 0; c < 5; c++) begin
        chk("stall_out_valid", out_valid, 1'b1);
        chk("stall_out_data", out_data, 8'h04);
        chk("stall_in_ready", in_ready, 1'b0);
        tick();
      end
      out_ready = 1'b1;
      n = 0;
      while (!rd_done && n < 100) begin
        chk("drain_in_ready", in_ready, 1'b0);
        tick(); n++;
      end
      if (n >= 100) timeout_fail("stall_done");
      out_ready = 1'b0;
      tick();
      chk("post_done_in_ready", in_ready, 1'b1);
      tick();
      chk("post_done_load_data", cph_data, 8'hFF);
      chk("post_done_load_enc", cph_encrypt, 1'b1);
      in_valid = 1'b0;
      tick(); tick(); tick();
    end

    // Reset during LD_PULSE, then read with count 0
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_inc", cph_inc, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_inc", cph_inc, 1'b0);
    chk("async_enc", cph_encrypt, 1'b0);
    chk("async_count", count, 4'd0);
    #2;
    rst_n = 1'b1;
    tick();
    rd_start = 1'b1; rd_view = 1'b0;
    tick();
    rd_start = 1'b0;
    chk("empty_rd_done", rd_done, 1'b1);
    chk("empty_out_valid", out_valid, 1'b0);
    tick();
    chk("empty_rd_done_end", rd_done, 1'b0);
    chk("empty_out_valid2", out_valid, 1'b0);
    chk("empty_count", count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
